apb_slave_regfile: RTL and testbench

- APB slave register file; sits directly downstream of apb_master and consumes its PSEL/PENABLE/PWRITE/PADDR/PWDATA.
- Returns PREADY, PRDATA and PSLVERR to the master's PREADY_i/PRDATA_i inputs.
- Provides NUM_REGS data registers, with register 0 a read-only ID.
- Inserts a configurable number of wait states per transfer.
- Flags error responses for out-of-range addresses and writes to the ID register.

---
 rtl/apb_slave_regfile.sv | 117 +++++++++++
 tb/tb_apb_slave_regfile.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// APB slave register file: NUM_REGS registers (reg 0 = read-only ID),
// WAIT_STATES wait cycles, PSLVERR on out-of-range or ID writes.
`timescale 1ns/1ps
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 'hA5
) (
  input  logic                  PCLK_i,
  input  logic                  PRESET_i,
  input  logic                  PSEL_i,
  input  logic                  PENABLE_i,
  input  logic                  PWRITE_i,
  input  logic [ADDR_WIDTH-1:0] PADDR_i,
  input  logic [DATA_WIDTH-1:0] PWDATA_i,
  output logic [DATA_WIDTH-1:0] PRDATA_o,
  output logic                  PREADY_o,
  output logic                  PSLVERR_o
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  setup;
  logic [ADDR_WIDTH-1:0] a_sel;
  logic                  w_sel;
  logic                  err_sel;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic [IW-1:0]         idx;

  // In IDLE the decode looks at the live bus so a zero-wait transfer
  // can present its response in the first access cycle.
  always_comb begin
    setup   = PSEL_i & ~PENABLE_i;
    a_sel   = (state == S_IDLE) ? PADDR_i : addr_q;
    w_sel   = (state == S_IDLE) ? PWRITE_i : wr_q;
    idx     = a_sel[IW-1:0];
    err_sel = (32'(a_sel) >= 32'(NUM_REGS))
            | (w_sel & (a_sel == '0));
    rd_sel  = '0;
    if (!w_sel && !err_sel) begin
      if (a_sel == '0) rd_sel = ID_VALUE;
      else             rd_sel = regs[idx];
    end
  end

  always_ff @(posedge PCLK_i or negedge PRESET_i) begin
    if (!PRESET_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      PRDATA_o  <= '0;
      PREADY_o  <= 1'b0;
      PSLVERR_o <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      PRDATA_o  <= '0;
      PREADY_o  <= 1'b0;
      PSLVERR_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (setup) begin
            addr_q  <= PADDR_i;
            wr_q    <= PWRITE_i;
            wdata_q <= PWDATA_i;
            cnt     <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state     <= S_DONE;
              PREADY_o  <= 1'b1;
              PSLVERR_o <= err_sel;
              PRDATA_o  <= rd_sel;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!PSEL_i) begin
            state <= S_IDLE;
          end else if (PENABLE_i) begin
            if (cnt <= 4'd1) begin
              state     <= S_DONE;
              PREADY_o  <= 1'b1;
              PSLVERR_o <= err_sel;
              PRDATA_o  <= rd_sel;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          // Commit only if the master held PSEL through the DONE cycle.
          if (PSEL_i && wr_q && !err_sel) regs[idx] <= wdata_q;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three instances with
// WAIT_STATES 0, 2 and 3 share the bus; PSEL selects one.
`timescale 1ns/1ps
module tb_apb_slave_regfile;

  logic       pclk;
  logic       prst;
  logic [2:0] psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] rdata [3];
  logic [2:0] ready;
  logic [2:0] err;

  int checks = 0;
  int passed = 0;
  int pulses [3] = '{0, 0, 0};

  apb_slave_regfile #(.WAIT_STATES(0)) u_ws0 (
    .PCLK_i(pclk), .PRESET_i(prst), .PSEL_i(psel[0]),
    .PENABLE_i(penable), .PWRITE_i(pwrite), .PADDR_i(paddr),
    .PWDATA_i(pwdata), .PRDATA_o(rdata[0]), .PREADY_o(ready[0]),
    .PSLVERR_o(err[0]));

  apb_slave_regfile #(.WAIT_STATES(2)) u_ws2 (
    .PCLK_i(pclk), .PRESET_i(prst), .PSEL_i(psel[1]),
    .PENABLE_i(penable), .PWRITE_i(pwrite), .PADDR_i(paddr),
    .PWDATA_i(pwdata), .PRDATA_o(rdata[1]), .PREADY_o(ready[1]),
    .PSLVERR_o(err[1]));

  apb_slave_regfile #(.WAIT_STATES(3)) u_ws3 (
    .PCLK_i(pclk), .PRESET_i(prst), .PSEL_i(psel[2]),
    .PENABLE_i(penable), .PWRITE_i(pwrite), .PADDR_i(paddr),
    .PWDATA_i(pwdata), .PRDATA_o(rdata[2]), .PREADY_o(ready[2]),
    .PSLVERR_o(err[2]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    for (int k = 0; k < 3; k++)
      if (ready[k] === 1'b1) pulses[k]++;
  end

  // One transfer. Entered at posedge+1; leaves at posedge+1 with the
  // bus idle so a following call is a back-to-back setup cycle.
  task automatic xfer(input int d, input logic wr,
                      input logic [7:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output logic er,
                      output int n);
    psel    = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = ~a;
    pwdata  = ~wd;
    pwrite  = ~wr;
    n  = 0;
    rd = '0;
    er = 1'b0;
    for (int i = 1; i <= 32 && n == 0; i++) begin
      @(negedge pclk);
      if (ready[d] === 1'b1) begin
        n  = i;
        rd = rdata[d];
        er = err[d];
      end else begin
        @(posedge pclk); #1;
      end
    end
    if (n == 0) begin
      checks++;
      $display("FAIL xfer_timeout d=%0d addr=%h got no PREADY want one", d, a);
    end
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    prst    = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checks++;
    if (ready !== 3'b000 || err !== 3'b000)
      $display("FAIL reset_flags got rdy=%b err=%b want 000/000", ready, err);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdata[k] !== 8'h00)
        $display("FAIL reset_rdata%0d got %h want 00", k, rdata[k]);
      else passed++;
    end
    prst = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_zero_wait();
    logic [7:0] rd; logic er; int n;
    xfer(0, 1'b1, 8'h05, 8'h3C, rd, er, n);
    checks++;
    if (n !== 1 || er !== 1'b0 || rd !== 8'h00)
      $display("FAIL zw_write got n=%0d err=%b rd=%h want 1/0/00", n, er, rd);
    else passed++;
    xfer(0, 1'b0, 8'h05, 8'h00, rd, er, n);
    checks++;
    if (n !== 1 || er !== 1'b0 || rd !== 8'h3C)
      $display("FAIL zw_read got n=%0d err=%b rd=%h want 1/0/3c", n, er, rd);
    else passed++;
  endtask

  task automatic test_boundary();
    logic [7:0] rd; logic er; int n;
    xfer(0, 1'b1, 8'h0F, 8'hC3, rd, er, n);
    xfer(0, 1'b0, 8'h0F, 8'h00, rd, er, n);
    checks++;
    if (er !== 1'b0 || rd !== 8'hC3)
      $display("FAIL top_reg got err=%b rd=%h want 0/c3", er, rd);
    else passed++;
    xfer(0, 1'b0, 8'h10, 8'h00, rd, er, n);
    checks++;
    if (er !== 1'b1 || rd !== 8'h00)
      $display("FAIL first_oor got err=%b rd=%h want 1/00", er, rd);
    else passed++;
  endtask

  task automatic test_wait_states();
    logic [7:0] rd; logic er; int n;
    xfer(1, 1'b0, 8'h00, 8'h00, rd, er, n);
    checks++;
    if (n !== 3 || er !== 1'b0 || rd !== 8'hA5)
      $display("FAIL ws2_id got n=%0d err=%b rd=%h want 3/0/a5", n, er, rd);
    else passed++;
  endtask

  task automatic test_errors();
    logic [7:0] rd; logic er; int n;
    xfer(1, 1'b1, 8'h00, 8'h77, rd, er, n);
    checks++;
    if (n !== 3 || er !== 1'b1)
      $display("FAIL id_write got n=%0d err=%b want 3/1", n, er);
    else passed++;
    xfer(1, 1'b1, 8'h20, 8'h11, rd, er, n);
    checks++;
    if (er !== 1'b1 || rd !== 8'h00)
      $display("FAIL oor_write got err=%b rd=%h want 1/00", er, rd);
    else passed++;
    xfer(1, 1'b0, 8'h00, 8'h00, rd, er, n);
    checks++;
    if (er !== 1'b0 || rd !== 8'hA5)
      $display("FAIL id_after got err=%b rd=%h want 0/a5", er, rd);
    else passed++;
    xfer(1, 1'b0, 8'h20, 8'h00, rd, er, n);
    checks++;
    if (er !== 1'b1 || rd !== 8'h00)
      $display("FAIL oor_read got err=%b rd=%h want 1/00", er, rd);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic er; int n;
    int p0;
    for (int i = 1; i <= 8; i++)
      xfer(0, 1'b1, 8'(i), 8'(8'h0F + i), rd, er, n);
    p0 = pulses[0];
    for (int i = 1; i <= 8; i++) begin
      xfer(0, 1'b0, 8'(i), 8'h00, rd, er, n);
      checks++;
      if (rd !== 8'(8'h0F + i) || er !== 1'b0)
        $display("FAIL b2b_read%0d got %h err=%b want %h/0",
                 i, rd, er, 8'(8'h0F + i));
      else passed++;
    end
    repeat (2) @(posedge pclk); #1;
    checks++;
    if (pulses[0] - p0 !== 8)
      $display("FAIL b2b_pulses got %0d want 8", pulses[0] - p0);
    else passed++;
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic er; int n;
    int p2;
    p2      = pulses[2];
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h04;
    pwdata  = 8'h99;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    repeat (6) @(posedge pclk); #1;
    checks++;
    if (pulses[2] !== p2)
      $display("FAIL abort_ready got %0d pulses want 0", pulses[2] - p2);
    else passed++;
    xfer(2, 1'b0, 8'h04, 8'h00, rd, er, n);
    checks++;
    if (n !== 4 || er !== 1'b0 || rd !== 8'h00)
      $display("FAIL abort_read got n=%0d err=%b rd=%h want 4/0/00",
               n, er, rd);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; logic er; int n;
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h02;
    pwdata  = 8'hEE;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk); #1;
    prst = 1'b0;
    #1;
    checks++;
    if (ready[2] !== 1'b0 || err[2] !== 1'b0 || rdata[2] !== 8'h00)
      $display("FAIL rst_wait got rdy=%b err=%b rd=%h want 0/0/00",
               ready[2], err[2], rdata[2]);
    else passed++;
    #2;
    prst    = 1'b1;
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge pclk); #1;
    xfer(2, 1'b0, 8'h02, 8'h00, rd, er, n);
    checks++;
    if (n !== 4 || er !== 1'b0 || rd !== 8'h00)
      $display("FAIL rst_read got n=%0d err=%b rd=%h want 4/0/00",
               n, er, rd);
    else passed++;
  endtask

  task automatic test_reset_done();
    logic [7:0] rd; logic er; int n;
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    checks++;
    if (ready[0] !== 1'b1 || rdata[0] !== 8'hA5)
      $display("FAIL pre_rst got rdy=%b rd=%h want 1/a5", ready[0], rdata[0]);
    else passed++;
    #1;
    prst = 1'b0;
    #1;
    checks++;
    if (ready[0] !== 1'b0 || rdata[0] !== 8'h00)
      $display("FAIL rst_done got rdy=%b rd=%h want 0/00", ready[0], rdata[0]);
    else passed++;
    #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge pclk); #1;
    xfer(0, 1'b0, 8'h00, 8'h00, rd, er, n);
    checks++;
    if (n !== 1 || rd !== 8'hA5)
      $display("FAIL rst_restart got n=%0d rd=%h want 1/a5", n, rd);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_boundary();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_reset_done();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
